// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer controller for a bisynchronous FIFO: owns the binary and
// Gray write pointers, synchronizes the remote Gray read pointer, and derives full/count.
module fifo_wptr_ctrl #(
  parameter int p_addr_width = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enq_val,
  output logic                    enq_rdy,
  output logic                    wen,
  output logic [p_addr_width-1:0] waddr,
  output logic [p_addr_width:0]   wptr_gray,
  input  logic [p_addr_width:0]   rptr_gray_async,
  output logic [p_addr_width:0]   count
);

  localparam int p_ptr_w = p_addr_width + 1;

  // Inverting the top two bits of the read Gray pointer gives the Gray code of
  // (read pointer + depth), i.e. the write pointer value at which the FIFO is full.
  localparam logic [p_ptr_w-1:0] full_mask = p_ptr_w'(3) << (p_ptr_w - 2);

  function automatic logic [p_ptr_w-1:0] bin_to_gray(input logic [p_ptr_w-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [p_ptr_w-1:0] gray_to_bin(input logic [p_ptr_w-1:0] g);
    logic [p_ptr_w-1:0] b;
    b[p_ptr_w-1] = g[p_ptr_w-1];
    for (int i = p_ptr_w - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [p_ptr_w-1:0] wptr_bin;
  logic [p_ptr_w-1:0] wptr_next;
  logic [p_ptr_w-1:0] wgray_next;
  logic [p_ptr_w-1:0] rs1;
  logic [p_ptr_w-1:0] rs2;
  logic [p_ptr_w-1:0] r_bin;
  logic               full;
  logic               fire;

  // Handshake is a zero-cycle decision from registered state; reset blocks
  // acceptance in the same cycle so a mid-transfer enq is discarded.
  assign enq_rdy    = ~full & ~reset;
  assign fire       = enq_val & enq_rdy;
  assign wen        = fire;
  assign waddr      = wptr_bin[p_addr_width-1:0];

  assign wptr_next  = wptr_bin + p_ptr_w'(fire);
  assign wgray_next = bin_to_gray(wptr_next);

  // Only the second synchronizer stage feeds logic; rs1 may be metastable.
  assign r_bin      = gray_to_bin(rs2);
  assign count      = wptr_bin - r_bin;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset here is synchronous, so it sits inside
  // the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_bin  <= '0;
      wptr_gray <= '0;
      rs1       <= '0;
      rs2       <= '0;
      full      <= 1'b0;
    end else begin
      wptr_bin  <= wptr_next;
      wptr_gray <= wgray_next;
      rs1       <= rptr_gray_async;
      rs2       <= rs1;
      // Compared against the current rs2, so a same-cycle read advance is
      // seen one edge later: conservative, never an overrun.
      full      <= (wgray_next == (rs2 ^ full_mask));
    end
  end

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Self-checking bench for fifo_wptr_ctrl: a cycle model plus a write scoreboard
// (expected address/Gray pushed at drive time, popped when the DUT raises wen).
module tb_fifo_wptr_ctrl;

  localparam int AW    = 3;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [PW-1:0] gray_after;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enq_val;
  logic          enq_rdy;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wptr_gray;
  logic [PW-1:0] rptr_gray_async;
  logic [PW-1:0] count;

  always #5 clk = ~clk;

  fifo_wptr_ctrl #(.p_addr_width(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .enq_val         (enq_val),
    .enq_rdy         (enq_rdy),
    .wen             (wen),
    .waddr           (waddr),
    .wptr_gray       (wptr_gray),
    .rptr_gray_async (rptr_gray_async),
    .count           (count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: binary write pointer, read pointer and its two synchronizer delays.
  int  m_wptr = 0;
  int  rp_bin = 0;
  int  rp_d1  = 0;
  int  rp_d2  = 0;
  bit  m_full = 1'b0;

  wr_t           sb[$];
  logic [PW-1:0] exp_gray;
  logic [PW-1:0] trace[$];
  logic [AW-1:0] last_waddr;
  int            fire_cnt;
  bit            last_fire;
  bit            last_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] to_gray(input int b);
    logic [PW-1:0] v;
    v = b[PW-1:0];
    return v ^ (v >> 1);
  endfunction

  task automatic drive(input bit r, input bit e, input int rp);
    wr_t w;
    reset           = r;
    enq_val         = e;
    rp_bin          = rp & (2 * DEPTH - 1);
    rptr_gray_async = to_gray(rp_bin);
    if (e && !r && !m_full) begin
      w.addr       = m_wptr[AW-1:0];
      w.gray_after = to_gray(m_wptr + 1);
      sb.push_back(w);
    end
  endtask

  task automatic step();
    wr_t w;
    bit  exp_fire;
    @(negedge clk);
    exp_fire = enq_val && !reset && !m_full;
    check("enq_rdy", enq_rdy, !reset && !m_full);
    check("wen", wen, exp_fire);
    check("count", count, (m_wptr - rp_d2) & (2 * DEPTH - 1));
    check("waddr", waddr, m_wptr & (DEPTH - 1));
    last_fire = wen;
    last_rdy  = enq_rdy;
    if (wen === 1'b1) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        w = sb.pop_front();
        check("sb_waddr", waddr, w.addr);
        exp_gray   = w.gray_after;
        last_waddr = waddr;
        fire_cnt++;
      end
    end
    @(posedge clk);
    if (reset) begin
      m_wptr = 0;
      rp_d1  = 0;
      rp_d2  = 0;
      m_full = 1'b0;
    end else begin
      m_wptr = (m_wptr + int'(exp_fire)) & (2 * DEPTH - 1);
      m_full = ((m_wptr - rp_d2) & (2 * DEPTH - 1)) == DEPTH;
      rp_d2  = rp_d1;
      rp_d1  = rp_bin;
    end
    #1;
    check("wptr_gray", wptr_gray, to_gray(m_wptr));
    if (last_fire) check("sb_gray", wptr_gray, exp_gray);
    if (trace.size() == 0 || wptr_gray != trace[$]) trace.push_back(wptr_gray);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] fill_gray [9];
    int  k;
    bit  cnt_ok;
    bit  wrapped;
    logic [PW-1:0] prev_gray;

    fill_gray = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

    // Bring registers out of X before the model starts checking.
    reset = 1'b1; enq_val = 1'b0; rptr_gray_async = '0;
    repeat (2) @(posedge clk);
    #1;
    drive(1, 0, 0); step();

    // Fill: 10 cycles of enq_val against a stationary read pointer.
    trace.delete();
    trace.push_back(wptr_gray);
    fire_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0); step();
    end
    check("fill_fires", fire_cnt, 8);
    check("fill_last_waddr", last_waddr, 7);
    check("fill_trace_len", trace.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < trace.size()) check("fill_gray_seq", trace[i], fill_gray[i]);
    end
    check("fill_gray_c", wptr_gray, 4'hC);
    check("fill_count", count, DEPTH);
    check("fill_rdy", enq_rdy, 0);

    // Drop while full.
    fire_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0); step();
    end
    check("drop_fires", fire_cnt, 0);
    check("drop_gray", wptr_gray, 4'hC);
    check("drop_count", count, DEPTH);

    // Release: read pointer moves to 1; enq_rdy must rise after edge t+3.
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, 1); step();
      if (last_rdy) begin
        k = i;
        break;
      end
    end
    check("release_latency", k, 4);
    check("release_waddr", last_waddr, 0);
    check("release_gray", wptr_gray, 4'hD);
    drive(0, 0, 1); step();
    check("refull_rdy", last_rdy, 0);

    // Wrap-around: read pointer trails by two entries.
    drive(1, 0, 0); step();
    fire_cnt = 0;
    cnt_ok   = 1'b1;
    wrapped  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      prev_gray = wptr_gray;
      drive(0, 1, (i < 2) ? 0 : m_wptr - 2); step();
      if (prev_gray == 4'h8 && wptr_gray == 4'h0) wrapped = 1'b1;
      if (i >= 2 && (count < 2 || count > 4)) cnt_ok = 1'b0;
    end
    check("wrap_fires", fire_cnt, 40);
    check("wrap_seen", wrapped, 1);
    check("wrap_cnt_range", cnt_ok, 1);

    // Reset mid-operation with enq_val held high.
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, m_wptr - 2); step();
    end
    drive(1, 1, 0); step();
    check("rst_wen", last_fire, 0);
    drive(0, 0, 0);
    #1;
    check("rst_gray", wptr_gray, 0);
    check("rst_count", count, 0);
    check("rst_rdy", enq_rdy, 1);
    check("rst_waddr", waddr, 0);
    step();

    // Simultaneous: the 8th fire happens in the cycle rs2 has just advanced to 1.
    fire_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, (i >= 6) ? 1 : 0); step();
    end
    check("simul_fires", fire_cnt, 8);
    check("simul_rdy", enq_rdy, 1);
    check("simul_count", count, 7);
    check("simul_gray", wptr_gray, 4'hC);
    drive(0, 0, 1); step();

    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
